// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Holds the frame field widths, the default sync marker and the framing FSM state type.
package imem_loader_pkg;

    localparam int BYTE_W = 8;
    localparam int LEN_W  = 16;
    localparam int WORD_W = 32;

    localparam logic [BYTE_W-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } loader_state_t;

endpackage

// File: rtl/imem_loader_packer.sv
// Assembles little-endian words from a byte stream and keeps the running XOR checksum.
// o_wordDone is combinational and fires in the same cycle the lane-3 byte is accepted.
module byte_to_word_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_en,
    input  logic [BYTE_W-1:0] i_byte,
    output logic [WORD_W-1:0] o_word,
    output logic              o_wordDone,
    output logic [BYTE_W-1:0] o_csum
);

    localparam int SHIFT_W = WORD_W - BYTE_W;

    logic [1:0]         r_lane;
    logic [SHIFT_W-1:0] r_shift;
    logic [BYTE_W-1:0]  r_csum;

    // Earlier bytes slide toward the low end, so after three bytes r_shift holds lanes 2..0.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_lane  <= '0;
            r_shift <= '0;
            r_csum  <= '0;
        end else if (i_en) begin
            r_lane  <= r_lane + 2'd1;
            r_shift <= {i_byte, r_shift[SHIFT_W-1:BYTE_W]};
            r_csum  <= r_csum ^ i_byte;
        end
    end

    assign o_word     = {i_byte, r_shift};
    assign o_wordDone = i_en && (r_lane == 2'd3);
    assign o_csum     = r_csum;

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: parses a framed byte stream, writes words into instruction memory
// and releases the core only once the whole frame has passed its XOR checksum.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int                ADDR_W    = 10,
    parameter logic [BYTE_W-1:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              err
);

    localparam logic [LEN_W:0] LEN_LIMIT = (LEN_W+1)'(1) << ADDR_W;

    loader_state_t r_state;
    loader_state_t w_nextState;

    logic [BYTE_W-1:0] r_lenLo;
    logic [ADDR_W:0]   r_wordCnt;
    logic [ADDR_W:0]   r_index;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [WORD_W-1:0] r_wdata;
    logic              r_done;
    logic              r_err;
    logic              r_hold;

    logic              w_xfer;
    logic [LEN_W-1:0]  w_len;
    logic [LEN_W:0]    w_lenExt;
    logic              w_tooBig;
    logic              w_lenZero;
    logic              w_lastWord;
    logic              w_pack;
    logic              w_clear;
    logic [WORD_W-1:0] w_word;
    logic              w_wordDone;
    logic [BYTE_W-1:0] w_csum;

    assign in_ready   = ~rst;
    assign w_xfer     = in_valid && in_ready;
    assign w_len      = {in_data, r_lenLo};
    assign w_lenExt   = {1'b0, w_len};
    assign w_tooBig   = w_lenExt > LEN_LIMIT;
    assign w_lenZero  = (w_len == '0);
    assign w_lastWord = (r_index == r_wordCnt - 1'b1);
    assign w_pack     = w_xfer && (r_state == S_DATA);
    assign w_clear    = w_xfer && (r_state == S_LEN1);

    byte_to_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_clear),
        .i_en       (w_pack),
        .i_byte     (in_data),
        .o_word     (w_word),
        .o_wordDone (w_wordDone),
        .o_csum     (w_csum)
    );

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_xfer && in_data == SYNC_BYTE) w_nextState = S_LEN0;
            end
            S_LEN0: begin
                if (w_xfer) w_nextState = S_LEN1;
            end
            S_LEN1: begin
                if (w_xfer) begin
                    if (w_tooBig)       w_nextState = S_ERROR;
                    else if (w_lenZero) w_nextState = S_CSUM;
                    else                w_nextState = S_DATA;
                end
            end
            S_DATA: begin
                if (w_wordDone && w_lastWord) w_nextState = S_CSUM;
            end
            S_CSUM: begin
                if (w_xfer) w_nextState = (in_data == w_csum) ? S_DONE : S_ERROR;
            end
            S_DONE: begin
                w_nextState = S_DONE;
            end
            S_ERROR: begin
                if (w_xfer && in_data == SYNC_BYTE) w_nextState = S_LEN0;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Status flags are registered from the next state so they move together with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_lenLo   <= '0;
            r_wordCnt <= '0;
            r_index   <= '0;
            r_we      <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_hold    <= 1'b1;
        end else begin
            r_state <= w_nextState;
            r_we    <= w_wordDone;
            if (w_xfer && r_state == S_LEN0) begin
                r_lenLo <= in_data;
            end
            if (w_clear) begin
                r_wordCnt <= w_lenExt[ADDR_W:0];
                r_index   <= '0;
            end
            if (w_wordDone) begin
                r_waddr <= r_index[ADDR_W-1:0];
                r_wdata <= w_word;
                r_index <= r_index + 1'b1;
            end
            r_done <= (w_nextState == S_DONE);
            r_err  <= (w_nextState == S_ERROR);
            r_hold <= (w_nextState != S_DONE);
        end
    end

    assign imem_we    = r_we;
    assign imem_waddr = r_waddr;
    assign imem_wdata = r_wdata;
    assign core_hold  = r_hold;
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (default depth and a 4-word memory) share one byte stream
// and are checked every cycle against a frame-level model, plus literal end-of-frame checks.
module tb_imem_loader;

    localparam logic [7:0] SYNC = 8'hA5;
    localparam int M_HUNT    = 0;
    localparam int M_COLLECT = 1;
    localparam int M_FIN     = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;

    logic        in_ready0, imem_we0, core_hold0, done0, err0;
    logic [9:0]  imem_waddr0;
    logic [31:0] imem_wdata0;
    logic        in_ready1, imem_we1, core_hold1, done1, err1;
    logic [1:0]  imem_waddr1;
    logic [31:0] imem_wdata1;

    int testCount = 0;
    int failCount = 0;

    // Frame-level model state, one slot per instance.
    int          mMode  [2];
    logic [7:0]  mBuf   [2][64];
    int          mCnt   [2];
    int          mN     [2];
    int          mDepth [2] = '{1024, 4};
    logic        mWe    [2];
    logic [31:0] mAddr  [2];
    logic [31:0] mData  [2];
    logic        mDone  [2];
    logic        mErr   [2];
    logic        mHold  [2];
    logic        modelPrimed = 1'b0;

    int          wrCnt    [2];
    logic [31:0] lastAddr [2];
    logic [31:0] lastData [2];

    logic [7:0]  frameOk [0:10] = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50,
                                    8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
    logic [31:0] wordBuf [0:7];

    always #5 clk = ~clk;

    imem_loader dut0 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready0),
        .imem_we    (imem_we0),
        .imem_waddr (imem_waddr0),
        .imem_wdata (imem_wdata0),
        .core_hold  (core_hold0),
        .done       (done0),
        .err        (err0)
    );

    imem_loader #(.ADDR_W(2)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready1),
        .imem_we    (imem_we1),
        .imem_waddr (imem_waddr1),
        .imem_wdata (imem_wdata1),
        .core_hold  (core_hold1),
        .done       (done1),
        .err        (err1)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset(input int d);
        mMode[d] = M_HUNT;
        mCnt[d]  = 0;
        mN[d]    = 0;
        mWe[d]   = 1'b0;
        mAddr[d] = 32'd0;
        mData[d] = 32'd0;
        mDone[d] = 1'b0;
        mErr[d]  = 1'b0;
        mHold[d] = 1'b1;
    endtask

    // Frame bytes after the sync marker are buffered; decisions come from the byte position.
    task automatic modelByte(input int d, input logic [7:0] b);
        int k;
        logic [7:0] x;
        if (mMode[d] == M_HUNT) begin
            if (b == SYNC) begin
                mMode[d] = M_COLLECT;
                mCnt[d]  = 0;
                mErr[d]  = 1'b0;
            end
        end else if (mMode[d] == M_COLLECT) begin
            if (mCnt[d] < 64) mBuf[d][mCnt[d]] = b;
            mCnt[d]++;
            k = mCnt[d];
            if (k == 2) begin
                mN[d] = int'({mBuf[d][1], mBuf[d][0]});
                if (mN[d] > mDepth[d]) begin
                    mMode[d] = M_HUNT;
                    mErr[d]  = 1'b1;
                end
            end else if (k == 3 + 4 * mN[d]) begin
                x = 8'h00;
                for (int i = 2; i < k - 1; i++) x ^= mBuf[d][i];
                if (x == b) begin
                    mMode[d] = M_FIN;
                    mDone[d] = 1'b1;
                    mHold[d] = 1'b0;
                end else begin
                    mMode[d] = M_HUNT;
                    mErr[d]  = 1'b1;
                end
            end else if (k > 2 && ((k - 2) % 4) == 0) begin
                mWe[d]   = 1'b1;
                mAddr[d] = 32'((k - 2) / 4 - 1);
                mData[d] = {mBuf[d][k-1], mBuf[d][k-2], mBuf[d][k-3], mBuf[d][k-4]};
            end
        end
    endtask

    task automatic modelStep();
        for (int d = 0; d < 2; d++) begin
            mWe[d] = 1'b0;
            if (rst) modelReset(d);
            else if (in_valid) modelByte(d, in_data);
        end
    endtask

    task automatic compareDut(input int d, input logic rdy, input logic we, input logic [31:0] addr,
                              input logic [31:0] data, input logic hold, input logic dn, input logic er);
        checkOutput($sformatf("dut%0d.in_ready", d), 32'(rdy), 32'(!rst));
        checkOutput($sformatf("dut%0d.imem_we", d), 32'(we), 32'(mWe[d]));
        checkOutput($sformatf("dut%0d.imem_waddr", d), addr, mAddr[d]);
        checkOutput($sformatf("dut%0d.imem_wdata", d), data, mData[d]);
        checkOutput($sformatf("dut%0d.core_hold", d), 32'(hold), 32'(mHold[d]));
        checkOutput($sformatf("dut%0d.done", d), 32'(dn), 32'(mDone[d]));
        checkOutput($sformatf("dut%0d.err", d), 32'(er), 32'(mErr[d]));
    endtask

    // One clock: compare on the falling edge, then advance the model on the rising edge.
    task automatic tick();
        @(negedge clk);
        if (modelPrimed) begin
            compareDut(0, in_ready0, imem_we0, 32'(imem_waddr0), imem_wdata0, core_hold0, done0, err0);
            compareDut(1, in_ready1, imem_we1, 32'(imem_waddr1), imem_wdata1, core_hold1, done1, err1);
        end
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                wrCnt[d] = 0;
                lastAddr[d] = 32'd0;
                lastData[d] = 32'd0;
            end
        end else begin
            if (imem_we0 === 1'b1) begin
                wrCnt[0]++;
                lastAddr[0] = 32'(imem_waddr0);
                lastData[0] = imem_wdata0;
            end
            if (imem_we1 === 1'b1) begin
                wrCnt[1]++;
                lastAddr[1] = 32'(imem_waddr1);
                lastData[1] = imem_wdata1;
            end
        end
        @(posedge clk);
        modelStep();
        modelPrimed = 1'b1;
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int gap);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic sendFramePrefix(input int nBytes, input int gap);
        for (int i = 0; i < nBytes; i++) applyStimulus(frameOk[i], gap);
    endtask

    task automatic sendHeader(input int n, input int gap);
        applyStimulus(SYNC, gap);
        applyStimulus(8'(n), gap);
        applyStimulus(8'(n >> 8), gap);
    endtask

    task automatic sendPayload(input int n, input int gap);
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        for (int w = 0; w < n; w++) begin
            for (int l = 0; l < 4; l++) begin
                b = wordBuf[w][8*l +: 8];
                x ^= b;
                applyStimulus(b, gap);
            end
        end
        applyStimulus(x, gap);
    endtask

    task automatic checkResult(input int d, input string tag, input int nWr, input logic [31:0] addr,
                               input logic [31:0] data, input logic dn, input logic er, input logic hold);
        logic a_done, a_err, a_hold;
        a_done = (d == 0) ? done0 : done1;
        a_err  = (d == 0) ? err0 : err1;
        a_hold = (d == 0) ? core_hold0 : core_hold1;
        checkOutput($sformatf("%s.dut%0d.writes", tag, d), 32'(wrCnt[d]), 32'(nWr));
        if (nWr > 0) begin
            checkOutput($sformatf("%s.dut%0d.last_addr", tag, d), lastAddr[d], addr);
            checkOutput($sformatf("%s.dut%0d.last_data", tag, d), lastData[d], data);
        end
        checkOutput($sformatf("%s.dut%0d.done", tag, d), 32'(a_done), 32'(dn));
        checkOutput($sformatf("%s.dut%0d.err", tag, d), 32'(a_err), 32'(er));
        checkOutput($sformatf("%s.dut%0d.core_hold", tag, d), 32'(a_hold), 32'(hold));
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            modelReset(d);
            wrCnt[d] = 0;
            lastAddr[d] = 32'd0;
            lastData[d] = 32'd0;
        end

        // Reset state
        tick();
        checkOutput("reset.in_ready_low", 32'(in_ready0), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("reset.in_ready_high", 32'(in_ready0), 32'd1);
        checkOutput("reset.core_hold", 32'(core_hold0), 32'd1);
        checkOutput("reset.imem_we", 32'(imem_we0), 32'd0);
        checkOutput("reset.imem_waddr", 32'(imem_waddr0), 32'd0);
        checkOutput("reset.imem_wdata", imem_wdata0, 32'd0);
        checkOutput("reset.done_err", 32'({done0, err0}), 32'd0);

        // Two-word program with correct checksum 0x71
        sendFramePrefix(11, 0);
        applyStimulus(8'h71, 0);
        idle(2);
        checkResult(0, "n2", 2, 32'd1, 32'h00A00113, 1'b1, 1'b0, 1'b0);
        checkResult(1, "n2", 2, 32'd1, 32'h00A00113, 1'b1, 1'b0, 1'b0);
        applyStimulus(SYNC, 0);
        idle(1);
        checkOutput("done_sticky", 32'(done0), 32'd1);

        // Bad checksum, then recovery by resending without reset
        doReset();
        sendFramePrefix(11, 0);
        applyStimulus(8'h00, 0);
        idle(2);
        checkResult(0, "badcsum", 2, 32'd1, 32'h00A00113, 1'b0, 1'b1, 1'b1);
        sendFramePrefix(11, 0);
        applyStimulus(8'h71, 0);
        idle(2);
        checkResult(0, "resend", 4, 32'd1, 32'h00A00113, 1'b1, 1'b0, 1'b0);

        // Leading garbage before a one-word frame
        doReset();
        applyStimulus(8'h11, 0);
        applyStimulus(8'h22, 0);
        wordBuf[0] = 32'hDEADBEEF;
        sendHeader(1, 0);
        sendPayload(1, 0);
        idle(2);
        checkResult(0, "garbage", 1, 32'd0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);

        // Empty frame
        doReset();
        applyStimulus(8'hA5, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h00, 0);
        idle(2);
        checkResult(0, "n0", 0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);

        // N=5: too long for the 4-word instance, fine for the default one
        doReset();
        wordBuf[0] = 32'h01020304;
        wordBuf[1] = 32'h05060708;
        wordBuf[2] = 32'h090A0B0C;
        wordBuf[3] = 32'h0D0E0F10;
        wordBuf[4] = 32'h11121314;
        sendHeader(5, 0);
        checkOutput("n5.dut1.err_after_len", 32'(err1), 32'd1);
        checkOutput("n5.dut0.err_after_len", 32'(err0), 32'd0);
        sendPayload(5, 0);
        idle(2);
        checkResult(0, "n5", 5, 32'd4, 32'h11121314, 1'b1, 1'b0, 1'b0);
        checkResult(1, "n5", 0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);

        // N=4 fills the small memory exactly
        doReset();
        wordBuf[0] = 32'h00000013;
        wordBuf[1] = 32'h00100093;
        wordBuf[2] = 32'h00208113;
        wordBuf[3] = 32'hFFF00193;
        sendHeader(4, 0);
        sendPayload(4, 0);
        idle(2);
        checkResult(0, "n4", 4, 32'd3, 32'hFFF00193, 1'b1, 1'b0, 1'b0);
        checkResult(1, "n4", 4, 32'd3, 32'hFFF00193, 1'b1, 1'b0, 1'b0);

        // Reset mid-frame after six bytes, then a clean load
        doReset();
        sendFramePrefix(6, 0);
        doReset();
        idle(3);
        checkResult(0, "midrst", 0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        sendFramePrefix(11, 0);
        applyStimulus(8'h71, 0);
        idle(2);
        checkResult(0, "afterrst", 2, 32'd1, 32'h00A00113, 1'b1, 1'b0, 1'b0);

        // Three idle cycles between every byte
        doReset();
        sendFramePrefix(11, 3);
        applyStimulus(8'h71, 3);
        idle(2);
        checkResult(0, "gaps", 2, 32'd1, 32'h00A00113, 1'b1, 1'b0, 1'b0);
        checkResult(1, "gaps", 2, 32'd1, 32'h00A00113, 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
